out_packet_writer: RTL and testbench
====================================

# out_packet_writer

Framer in the control clock domain that turns packet requests from the audio control logic into a byte stream written to the host-bound (out) async FIFO feeding the FT2232 FIFO bridge. It is the transmit-side counterpart of the command parser that drains the in FIFO. Each packet carries a sync byte, a type byte, a length byte, the payload and a checksum. It obeys FIFO full/almost-full flow control and pads stalled payloads so that the host never sees a truncated frame.

## Interface
- PAYLOAD_TIMEOUT_CLKS, 1024: cycles without an offered payload byte, while not back-pressured, before the block pads.
- SYNC_BYTE, 8'h5A: first byte of every packet.
- PAD_BYTE, 8'h00: byte substituted on a payload timeout.

Ports:
- clk_24576000_i  in  1  sole clock.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  packet request pending.
- req_ready_o  out  1  request accepted this cycle when high together with req_valid_i.
- req_type_i  in  8  packet type, sampled at acceptance.
- req_len_i  in  8  payload byte count, 0..255, sampled at acceptance.
- pl_valid_i  in  1  payload byte offered.
- pl_ready_o  out  1  payload byte consumed this cycle when high together with pl_valid_i.
- pl_data_i  in  8  payload byte.
- done_o  out  1  one-cycle pulse after the checksum byte is written.
- timeout_err_o  out  1  one-cycle pulse when padding starts in a packet.
- wr_out_fifo_clk_o  out  1  equal to clk_24576000_i.
- wr_out_fifo_en_o  out  1  write strobe.
- wr_out_fifo_data_o  out  8  write data.
- wr_out_fifo_full_i  in  1  out FIFO full.
- wr_out_fifo_afull_i  in  1  out FIFO almost full.

## Operation
- States: IDLE, SYNC, TYPE, LEN, PAYLOAD, CSUM.
- IDLE: req_ready_o = ~wr_out_fifo_afull_i.
  - On acceptance, latch type and len, clear the checksum accumulator, clear the timeout counter, and go to SYNC.
- SYNC, TYPE, LEN, CSUM each emit exactly one byte.
  - wr_out_fifo_en_o = ~wr_out_fifo_full_i, combinational.
  - The state advances only on a cycle in which en is high.
  - Data is SYNC_BYTE, the latched type, the latched len, or the checksum respectively.
- LEN → PAYLOAD when len ≠ 0. LEN → CSUM when len = 0.
- PAYLOAD, normal mode:
  - pl_ready_o = ~wr_out_fifo_full_i.
  - wr_out_fifo_en_o = pl_valid_i & pl_ready_o.
  - wr_out_fifo_data_o = pl_data_i, passed through in the same cycle.
  - The remaining count decrements per written byte. After the last byte, go to CSUM.
- Timeout:
  - The counter increments in PAYLOAD on cycles with ~pl_valid_i & ~wr_out_fifo_full_i. It clears on every accepted byte.
  - When it reaches PAYLOAD_TIMEOUT_CLKS, pulse timeout_err_o and enter pad mode.
- Pad mode, for the remainder of the packet:
  - pl_ready_o = 0.
  - wr_out_fifo_en_o = ~wr_out_fifo_full_i.
  - Data is PAD_BYTE.
- Checksum:
  - 8-bit modulo-256 sum of type, len and every payload byte actually written, pad bytes included.
  - The CSUM byte is the two's complement of that sum, so type + len + payload + csum ≡ 0 mod 256.
- CSUM written → IDLE, and done_o pulses in the next cycle.
- wr_out_fifo_en_o is never high while wr_out_fifo_full_i is high, in any state.
- wr_out_fifo_afull_i gates only the start of a packet. Once a packet starts, only full stalls it.
- pl_ready_o is 0 outside PAYLOAD normal mode. Payload bytes offered in other states are not consumed.
- Reset, including mid-packet:
  - State IDLE; counters and accumulator zero.
  - req_ready_o, pl_ready_o, done_o, timeout_err_o, wr_out_fifo_en_o all 0; wr_out_fifo_data_o 8'h00.
  - Bytes already in the FIFO stay there. The host resynchronises on SYNC_BYTE plus checksum.

## Timing
- Acceptance at cycle T0 with no back-pressure:
  - SYNC written at T1, TYPE at T2, LEN at T3.
  - Payload at T4..T3+L.
  - CSUM at T4+L.
  - done_o high at T5+L, with state IDLE. req_ready_o may be high that same cycle.
- Best-case packet spacing is L+5 cycles from one acceptance to the next.
- A full_i stall holds the current byte and state; there is no byte loss and no duplication.
- wr_out_fifo_en_o and pl_ready_o are combinational from full_i and pl_valid_i. All other outputs are registered.

## Structure
- Package out_packet_pkg holds:
  - the state enum;
  - the SYNC_BYTE and PAD_BYTE defaults;
  - the packet type code constants shared with the command parser and the host software.
- No sub-module is needed. The timeout counter is $clog2(PAYLOAD_TIMEOUT_CLKS+1) bits wide and lives inline.

## Test plan
- **Basic packet.** Request type 8'h10, len 3, payload 01 02 03, full held low → FIFO receives 5A 10 03 01 02 03 E7; done_o one cycle after E7.
- **Zero length.** Request type 8'h22, len 0 → FIFO receives 5A 22 00 DE; pl_ready_o never asserts.
- **Back-pressure.** Assert full for 4 cycles during the second payload byte, then release → identical byte sequence, en never high while full, no payload consumed while full.
- **Almost full.** afull high with req_valid_i high → req_ready_o stays 0 and no writes occur. Drop afull → packet starts the next cycle.
- **Timeout.** len 4, one payload byte 8'hFF, then pl_valid_i held low with PAYLOAD_TIMEOUT_CLKS=8 → timeout_err_o pulses once, FIFO receives 5A t 04 FF 00 00 00 with csum = −(t+4+FF) mod 256.
- **Reset mid-packet.** Assert reset_i after the TYPE byte → next cycle all outputs at reset values. A new request then produces a complete, correct packet.

Source files
------------

// File: rtl/out_packet_pkg.sv
// Shared definitions for the host-bound packet framer: FSM states, framing
// byte defaults and the packet type codes also used by the command parser and host software.
package out_packet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    TYPE,
    LEN,
    PAYLOAD,
    CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h5A;
  localparam logic [7:0] PAD_BYTE_DEFAULT  = 8'h00;
  localparam int unsigned PAYLOAD_TIMEOUT_CLKS_DEFAULT = 1024;

  // Type codes agreed with the host software.
  localparam logic [7:0] PKT_TYPE_ACK    = 8'h10;
  localparam logic [7:0] PKT_TYPE_STATUS = 8'h22;
  localparam logic [7:0] PKT_TYPE_METER  = 8'h33;
  localparam logic [7:0] PKT_TYPE_ERROR  = 8'h44;

  // Byte that brings type + len + payload + csum to zero modulo 256.
  function automatic logic [7:0] csum_byte(input logic [7:0] sum);
    return ~sum + 8'd1;
  endfunction

endpackage

// File: rtl/out_packet_writer.sv
// Frames packet requests into SYNC/TYPE/LEN/payload/CSUM bytes for the out FIFO,
// honouring full/almost-full and padding payloads that stall too long.
module out_packet_writer
  import out_packet_pkg::*;
#(
  parameter int unsigned PAYLOAD_TIMEOUT_CLKS = PAYLOAD_TIMEOUT_CLKS_DEFAULT,
  parameter logic [7:0]  SYNC_BYTE            = SYNC_BYTE_DEFAULT,
  parameter logic [7:0]  PAD_BYTE             = PAD_BYTE_DEFAULT
) (
  input  logic       clk_24576000_i,
  input  logic       reset_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [7:0] req_type_i,
  input  logic [7:0] req_len_i,
  input  logic       pl_valid_i,
  output logic       pl_ready_o,
  input  logic [7:0] pl_data_i,
  output logic       done_o,
  output logic       timeout_err_o,
  output logic       wr_out_fifo_clk_o,
  output logic       wr_out_fifo_en_o,
  output logic [7:0] wr_out_fifo_data_o,
  input  logic       wr_out_fifo_full_i,
  input  logic       wr_out_fifo_afull_i
);

  localparam int TW = $clog2(PAYLOAD_TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(PAYLOAD_TIMEOUT_CLKS - 1);

  state_t        state_reg, state_next;
  logic [7:0]    type_reg, len_reg, remain_reg, csum_reg;
  logic [TW-1:0] tmo_reg;
  logic          pad_reg, done_reg, tmo_err_reg, req_ready_reg;
  logic          wr_en, pl_ready, accept;
  logic [7:0]    wr_data;

  assign accept = req_valid_i & req_ready_reg & (state_reg == IDLE);

  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    pl_ready   = 1'b0;
    case (state_reg)
      IDLE: if (accept) state_next = SYNC;
      SYNC: begin
        wr_en   = ~wr_out_fifo_full_i;
        wr_data = SYNC_BYTE;
        if (wr_en) state_next = TYPE;
      end
      TYPE: begin
        wr_en   = ~wr_out_fifo_full_i;
        wr_data = type_reg;
        if (wr_en) state_next = LEN;
      end
      LEN: begin
        wr_en   = ~wr_out_fifo_full_i;
        wr_data = len_reg;
        if (wr_en) state_next = (len_reg == 8'd0) ? CSUM : PAYLOAD;
      end
      PAYLOAD: begin
        if (pad_reg) begin
          wr_en   = ~wr_out_fifo_full_i;
          wr_data = PAD_BYTE;
        end else begin
          pl_ready = ~wr_out_fifo_full_i;
          wr_en    = pl_valid_i & pl_ready;
          wr_data  = pl_data_i;
        end
        if (wr_en && remain_reg == 8'd1) state_next = CSUM;
      end
      CSUM: begin
        wr_en   = ~wr_out_fifo_full_i;
        wr_data = csum_byte(csum_reg);
        if (wr_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A mid-packet reset must not leak a partial byte into the FIFO.
    if (reset_i) begin
      wr_en    = 1'b0;
      pl_ready = 1'b0;
    end
  end

  always_ff @(posedge clk_24576000_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      type_reg      <= 8'h00;
      len_reg       <= 8'h00;
      remain_reg    <= 8'h00;
      csum_reg      <= 8'h00;
      tmo_reg       <= '0;
      pad_reg       <= 1'b0;
      done_reg      <= 1'b0;
      tmo_err_reg   <= 1'b0;
      req_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= (state_next == IDLE) & ~wr_out_fifo_afull_i;
      done_reg      <= (state_reg == CSUM) & wr_en;
      tmo_err_reg   <= 1'b0;
      if (accept) begin
        type_reg   <= req_type_i;
        len_reg    <= req_len_i;
        remain_reg <= req_len_i;
        csum_reg   <= 8'h00;
        tmo_reg    <= '0;
        pad_reg    <= 1'b0;
      end
      if (wr_en && (state_reg inside {TYPE, LEN, PAYLOAD}))
        csum_reg <= csum_reg + wr_data;
      if (state_reg == PAYLOAD) begin
        if (wr_en) remain_reg <= remain_reg - 8'd1;
        if (!pad_reg) begin
          if (wr_en) begin
            tmo_reg <= '0;
          end else if (!pl_valid_i && !wr_out_fifo_full_i) begin
            tmo_reg <= tmo_reg + 1'b1;
            if (tmo_reg == TMO_LAST) begin
              pad_reg     <= 1'b1;
              tmo_err_reg <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign req_ready_o        = req_ready_reg;
  assign pl_ready_o         = pl_ready;
  assign done_o             = done_reg;
  assign timeout_err_o      = tmo_err_reg;
  assign wr_out_fifo_clk_o  = clk_24576000_i;
  assign wr_out_fifo_en_o   = wr_en;
  assign wr_out_fifo_data_o = wr_data;

endmodule

// File: tb/tb_out_packet_writer.sv
// Directed bench for out_packet_writer: expected FIFO bytes are queued per request
// and popped by a monitor on every write strobe.
module tb_out_packet_writer;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [7:0] req_type_i = 8'h00;
  logic [7:0] req_len_i = 8'h00;
  logic       pl_valid_i = 1'b0;
  logic       pl_ready_o;
  logic [7:0] pl_data_i = 8'h00;
  logic       done_o;
  logic       timeout_err_o;
  logic       wr_out_fifo_clk_o;
  logic       wr_out_fifo_en_o;
  logic [7:0] wr_out_fifo_data_o;
  logic       wr_out_fifo_full_i = 1'b0;
  logic       wr_out_fifo_afull_i = 1'b0;

  always #5 clk = ~clk;

  out_packet_writer #(.PAYLOAD_TIMEOUT_CLKS(TMO)) dut (
    .clk_24576000_i      (clk),
    .reset_i             (reset_i),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_type_i          (req_type_i),
    .req_len_i           (req_len_i),
    .pl_valid_i          (pl_valid_i),
    .pl_ready_o          (pl_ready_o),
    .pl_data_i           (pl_data_i),
    .done_o              (done_o),
    .timeout_err_o       (timeout_err_o),
    .wr_out_fifo_clk_o   (wr_out_fifo_clk_o),
    .wr_out_fifo_en_o    (wr_out_fifo_en_o),
    .wr_out_fifo_data_o  (wr_out_fifo_data_o),
    .wr_out_fifo_full_i  (wr_out_fifo_full_i),
    .wr_out_fifo_afull_i (wr_out_fifo_afull_i)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  bit         last_q[$];
  bit         done_exp = 0;
  int         wr_count = 0;
  int         tmo_pulses = 0;
  int         pl_ready_seen = 0;
  logic [7:0] pbuf [0:7];

  // Monitor: every write is matched against the scoreboard, done_o must follow the CSUM write.
  always @(negedge clk) begin
    logic [7:0] exp_d;
    bit         lst;
    if (!reset_i) begin
      checks++;
      assert (done_o === done_exp) else begin
        errors++; $error("FAIL done_o observed %b expected %b", done_o, done_exp);
      end
    end
    done_exp = 0;
    if (pl_ready_o === 1'b1) pl_ready_seen++;
    if (timeout_err_o === 1'b1) tmo_pulses++;
    if (wr_out_fifo_full_i) begin
      checks++;
      assert (wr_out_fifo_en_o === 1'b0 && pl_ready_o === 1'b0) else begin
        errors++; $error("FAIL while_full observed en=%b pl_ready=%b expected 0 0", wr_out_fifo_en_o, pl_ready_o);
      end
    end
    if (wr_out_fifo_en_o === 1'b1) begin
      wr_count++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++; $error("FAIL unexpected_write observed %h expected no write", wr_out_fifo_data_o);
      end
      if (exp_q.size() != 0) begin
        exp_d = exp_q.pop_front();
        lst   = last_q.pop_front();
        checks++;
        assert (wr_out_fifo_data_o === exp_d) else begin
          errors++; $error("FAIL fifo_byte observed %h expected %h", wr_out_fifo_data_o, exp_d);
        end
        done_exp = lst;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit lst);
    exp_q.push_back(b);
    last_q.push_back(lst);
  endtask

  // Bytes past n_real are expected as pad bytes (0x00).
  task automatic expect_packet(input logic [7:0] t, input logic [7:0] l, input int n_real);
    logic [7:0] sum;
    logic [7:0] b;
    sum = t + l;
    push(8'h5A, 0);
    push(t, 0);
    push(l, 0);
    for (int i = 0; i < int'(l); i++) begin
      b = (i < n_real) ? pbuf[i] : 8'h00;
      sum = sum + b;
      push(b, 0);
    end
    push(8'h00 - sum, 1);
  endtask

  task automatic start_req(input logic [7:0] t, input logic [7:0] l, output int waits);
    bit got;
    got = 0;
    waits = 0;
    req_type_i  = t;
    req_len_i   = l;
    req_valid_i = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = req_ready_o;
      waits++;
      @(posedge clk);
      #1;
    end
    req_valid_i = 1'b0;
    checks++;
    assert (got) else begin
      errors++; $error("FAIL req_accept observed ready=0 expected ready=1 within 20 cycles");
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit fired;
    fired = 0;
    pl_valid_i = 1'b1;
    pl_data_i  = d;
    for (int i = 0; i < 40 && !fired; i++) begin
      @(negedge clk);
      fired = pl_ready_o;
      @(posedge clk);
      #1;
    end
    pl_valid_i = 1'b0;
    checks++;
    assert (fired) else begin
      errors++; $error("FAIL payload_accept byte %h observed not consumed expected consumed", d);
    end
  endtask

  task automatic wait_done(input logic [7:0] t);
    bit got;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = done_o;
    end
    @(posedge clk);
    #1;
    checks++;
    assert (got) else begin
      errors++; $error("FAIL done_wait type %h observed no done expected done", t);
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL bytes_left type %h observed %0d expected 0", t, exp_q.size());
    end
    $display("packet type %h complete at %0t", t, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (req_ready_o === 1'b0 && pl_ready_o === 1'b0 && done_o === 1'b0 &&
            timeout_err_o === 1'b0 && wr_out_fifo_en_o === 1'b0 && wr_out_fifo_data_o === 8'h00)
    else begin
      errors++;
      $error("FAIL %s observed rdy=%b plr=%b done=%b tmo=%b en=%b data=%h expected 0 0 0 0 0 00",
             tag, req_ready_o, pl_ready_o, done_o, timeout_err_o, wr_out_fifo_en_o, wr_out_fifo_data_o);
    end
  endtask

  initial begin
    int waits;
    int w0;
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    int w0;

    // Power-on reset
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset_state");
    tick();
    reset_i = 1'b0;
    tick();

    // Basic packet
    pbuf[0] = 8'h01; pbuf[1] = 8'h02; pbuf[2] = 8'h03;
    expect_packet(8'h10, 8'd3, 3);
    start_req(8'h10, 8'd3, waits);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    wait_done(8'h10);

    // Zero length, with a payload byte offered that must never be taken
    pl_ready_seen = 0;
    pl_valid_i = 1'b1;
    pl_data_i  = 8'h77;
    expect_packet(8'h22, 8'd0, 0);
    start_req(8'h22, 8'd0, waits);
    wait_done(8'h22);
    pl_valid_i = 1'b0;
    checks++;
    assert (pl_ready_seen == 0) else begin
      errors++; $error("FAIL zero_len_pl_ready observed %0d cycles expected 0", pl_ready_seen);
    end

    // Back-pressure on the second payload byte
    pbuf[0] = 8'hAA; pbuf[1] = 8'hBB; pbuf[2] = 8'hCC;
    expect_packet(8'h33, 8'd3, 3);
    start_req(8'h33, 8'd3, waits);
    send_byte(8'hAA);
    pl_valid_i = 1'b1;
    pl_data_i  = 8'hBB;
    wr_out_fifo_full_i = 1'b1;
    repeat (4) tick();
    wr_out_fifo_full_i = 1'b0;
    send_byte(8'hBB);
    send_byte(8'hCC);
    wait_done(8'h33);

    // Almost full holds off the request; once started it only obeys full
    wr_out_fifo_afull_i = 1'b1;
    tick();
    req_type_i  = 8'h55;
    req_len_i   = 8'd1;
    req_valid_i = 1'b1;
    w0 = wr_count;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      assert (req_ready_o === 1'b0) else begin
        errors++; $error("FAIL afull_ready observed %b expected 0", req_ready_o);
      end
      tick();
    end
    checks++;
    assert (wr_count == w0) else begin
      errors++; $error("FAIL afull_writes observed %0d expected 0", wr_count - w0);
    end
    pbuf[0] = 8'h9C;
    expect_packet(8'h55, 8'd1, 1);
    wr_out_fifo_afull_i = 1'b0;
    start_req(8'h55, 8'd1, waits);
    checks++;
    assert (waits <= 2) else begin
      errors++; $error("FAIL afull_release_latency observed %0d expected <=2", waits);
    end
    wr_out_fifo_afull_i = 1'b1;
    send_byte(8'h9C);
    wait_done(8'h55);
    wr_out_fifo_afull_i = 1'b0;
    tick();

    // Payload timeout pads the remaining bytes
    pbuf[0] = 8'hFF;
    tmo_pulses = 0;
    expect_packet(8'h44, 8'd4, 1);
    start_req(8'h44, 8'd4, waits);
    send_byte(8'hFF);
    wait_done(8'h44);
    checks++;
    assert (tmo_pulses == 1) else begin
      errors++; $error("FAIL timeout_pulses observed %0d expected 1", tmo_pulses);
    end

    // Reset after the TYPE byte, then a clean packet
    pbuf[0] = 8'h11; pbuf[1] = 8'h22;
    expect_packet(8'h66, 8'd2, 2);
    start_req(8'h66, 8'd2, waits);
    for (int i = 0; i < 20 && exp_q.size() > 4; i++) tick();
    checks++;
    assert (exp_q.size() == 4) else begin
      errors++; $error("FAIL reach_type observed %0d left expected 4", exp_q.size());
    end
    reset_i = 1'b1;
    exp_q.delete();
    last_q.delete();
    done_exp = 0;
    tick();
    @(negedge clk);
    check_reset_outputs("reset_mid_packet");
    tick();
    reset_i = 1'b0;
    tick();
    expect_packet(8'h66, 8'd2, 2);
    start_req(8'h66, 8'd2, waits);
    send_byte(8'h11);
    send_byte(8'h22);
    wait_done(8'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
